sync_ram_dp: RTL
================

# sync_ram_dp

Parametrised simple-dual-port synchronous RAM for simulation: one write port, one read port with registered one-cycle read latency, configurable depth independent of address width, selectable read-during-write behaviour, and an optional post-reset zero-clear sweep. Replaces the single-port combinational-read RAM in the CPU memory path wherever a registered read and an independent write path are needed. Simulation-only: compilation without `SIM` defined is a hard error.

## Interface
- `WIDTH`, 16, data word width in bits (≥1).
- `AW`, 8, address width in bits (1..16).
- `DEPTH`, 256, number of words; must satisfy 1 ≤ `DEPTH` ≤ 2^`AW`.
- `RDW_MODE`, 0, read-during-write to the same address: 0 = old data, 1 = new data.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ready`  out  1  high when both ports accept operations.
- `wr_en`  in  1  write strobe; sampled only when `ready`=1.
- `wr_addr`  in  `AW`  write address.
- `wr_din`  in  `WIDTH`  write data.
- `rd_en`  in  1  read strobe; sampled only when `ready`=1.
- `rd_addr`  in  `AW`  read address.
- `rd_valid`  out  1  one-cycle pulse: `rd_data`/`rd_err` valid.
- `rd_data`  out  `WIDTH`  read data, held until the next accepted read.
- `rd_err`  out  1  accepted read had `rd_addr` ≥ `DEPTH`.
- `wr_err`  out  1  sticky: some accepted write had `wr_addr` ≥ `DEPTH`; cleared only by reset.

## Operation
- States: CLEAR (only with `RAM_CLEAR_EN`), RUN.
- Reset values: `ready`=0, `rd_valid`=0, `rd_data`=0, `rd_err`=0, `wr_err`=0, clear counter=0. State = CLEAR if macro is defined, else RUN.
- CLEAR: each cycle writes 0 to word at the counter address, then increments; after writing word `DEPTH`-1, the state becomes RUN. `ready`=0 throughout. `wr_en`/`rd_en` are ignored, with no side effects.
- RUN: `ready`=1 permanently (registered output).
- Write: `ready`&`wr_en`, `wr_addr` < `DEPTH` → word updated at the edge. With `wr_addr` ≥ `DEPTH` → memory unchanged and `wr_err` set.
- Read: `ready`&`rd_en` → on the next edge, `rd_valid`=1, `rd_data`=mem[`rd_addr`], `rd_err`=0. With `rd_addr` ≥ `DEPTH` → `rd_data`=0 and `rd_err`=1.
- Read and write to the same in-range address in the same cycle: `RDW_MODE`=0 returns the pre-write word; `RDW_MODE`=1 returns `wr_din`. Different addresses are independent.
- No read accepted → `rd_valid`=0 next cycle. `rd_data`/`rd_err` hold their last values.
- Address compare is full `AW` bits. There is no wrap-around or aliasing modulo `DEPTH`.
- Reset asserted at any time, including mid-CLEAR: all outputs return to reset values immediately. A partial sweep restarts from address 0 after `rst_n` rises. Memory contents are not touched by reset itself.

## Timing
- Read latency: exactly 1 cycle, request edge → data edge. Throughput: one read and one write every cycle.
- Write visible to a read accepted on the following cycle or later.
- CLEAR duration: exactly `DEPTH` cycles after the first rising edge with `rst_n`=1. `ready` rises on edge `DEPTH`.
- No combinational path from any input to any output.

## Configuration
- `RAM_CLEAR_EN` defined: CLEAR state and `$clog2(DEPTH)`-bit counter compiled in. Every word reads 0 until written.
- Not defined: no counter. The block enters RUN directly, with `ready`=1 on the first edge after reset release. Unwritten words read X.

## Test plan
- Reset/clear, `DEPTH`=256, macro on: release `rst_n` → `ready`=0 for 256 cycles, then 1. Read addr 0x80 → `rd_valid` one cycle later, `rd_data`=0.
- Back-to-back: write 0xBEEF @0x10, then read 0x10 next cycle → `rd_data`=0xBEEF, `rd_valid` single-cycle pulse. Streamed reads 0x10..0x13 on consecutive cycles → 4 consecutive valid pulses.
- Same-cycle RDW @0x20 (old 0x1111, new 0x2222): `RDW_MODE`=0 → 0x1111; `RDW_MODE`=1 → 0x2222. Re-read → 0x2222 in both modes.
- Out of range, `DEPTH`=200, `AW`=8: write 0xAAAA @0xC8 → `wr_err`=1 and stays 1. Read 0xC8 → `rd_data`=0, `rd_err`=1. Read 0x48 unchanged (no aliasing).
- Reset mid-clear: assert `rst_n`=0 at clear cycle 100 → `ready`=0 at once. Release → `ready` rises exactly 256 cycles later.
- Macro off: `ready`=1 one edge after release. Strobes while `ready`=0 during reset produce no `rd_valid`.

Source files
------------

// File: rtl/sync_ram_dp.sv
// Simple dual-port RAM with a one-cycle registered read and selectable read-during-write.
// Define RAM_CLEAR_EN to zero-fill the array after reset; SIM must be defined.
module sync_ram_dp #(
  parameter int WIDTH    = 16,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             ready_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_din_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_err_o,
  output logic             wr_err_o
);

  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

`ifndef SIM
  if (1) begin : g_need_sim
    $fatal(1, "sync_ram_dp is simulation-only: define SIM");
  end
`endif

  if (WIDTH < 1 || AW < 1 || AW > 16 || DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_param
    $fatal(1, "sync_ram_dp: illegal WIDTH/AW/DEPTH combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ready_q, ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_err_q, wr_err_d;

  logic             wr_ok, rd_ok, wr_in_rng, rd_in_rng, rdw_hit;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             mem_we;
  logic [IW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // Full-width compare: out-of-range addresses never alias into the array.
  assign wr_in_rng = {1'b0, wr_addr_i} < DEPTH_L;
  assign rd_in_rng = {1'b0, rd_addr_i} < DEPTH_L;
  assign wr_idx    = wr_addr_i[IW-1:0];
  assign rd_idx    = rd_addr_i[IW-1:0];
  assign wr_ok     = ready_q & wr_en_i;
  assign rd_ok     = ready_q & rd_en_i;
  assign rdw_hit   = wr_ok & wr_in_rng & (wr_addr_i == rd_addr_i);

`ifdef RAM_CLEAR_EN
  // state   | meaning
  // S_CLEAR | sweeping zeros into the array, ports closed
  // S_RUN   | normal operation, ready_o high
  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    if (state_q == S_CLEAR) begin
      if (clr_cnt_q == IW'(DEPTH - 1)) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end
`else
  assign ready_d = 1'b1;
`endif

  always_comb begin
    mem_we    = wr_ok & wr_in_rng;
    mem_waddr = wr_idx;
    mem_wdata = wr_din_i;
`ifdef RAM_CLEAR_EN
    // Gated by rst_ni so that holding reset never sweeps the array.
    if (state_q == S_CLEAR) begin
      mem_we    = rst_ni;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
`endif
  end

  always_comb begin
    rd_valid_d = rd_ok;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    wr_err_d   = wr_err_q | (wr_ok & ~wr_in_rng);
    if (rd_ok) begin
      if (!rd_in_rng) begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
      end else begin
        rd_err_d  = 1'b0;
        rd_data_d = ((RDW_MODE != 0) && rdw_hit) ? wr_din_i : mem_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
`ifdef RAM_CLEAR_EN
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
`endif
    end else begin
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
`ifdef RAM_CLEAR_EN
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
`endif
    end
  end

  assign ready_o    = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_err_o   = rd_err_q;
  assign wr_err_o   = wr_err_q;

endmodule
